// File: rtl/calc_pkg.sv
// Shared constants, state encoding and series divisor table for the
// calculator's cosine sequencer.
package calc_pkg;

    localparam int unsigned SCALE_FP    = 10000;
    localparam int unsigned DEG_FULL    = 360;
    localparam int unsigned DEG_QUARTER = 90;
    localparam int unsigned RAD_NUM     = 22;
    localparam int unsigned RAD_DEN     = 1260;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REDUCE   = 3'd1,
        ST_SCALE    = 3'd2,
        ST_TERM_MUL = 3'd3,
        ST_TERM_DIV = 3'd4,
        ST_DONE     = 3'd5
    } cos_state_t;

    // (2k-1)*(2k) for k=1..7; entry 0 is a safe non-zero filler
    localparam logic [31:0] FACT_PAIR [0:7] = '{
        32'd1, 32'd2, 32'd12, 32'd30, 32'd56, 32'd90, 32'd132, 32'd182
    };

endpackage

// File: rtl/cos_quadrant_map.sv
// Folds a reduced angle (0..359 degrees) into the first quadrant with a sign.
// With COS_SIN_SEL_EN defined, a sin_sel input selects the sine mapping.
module cos_quadrant_map
    import calc_pkg::*;
(
    input  logic [8:0] d,
`ifdef COS_SIN_SEL_EN
    input  logic       sin_sel,
`endif
    output logic [6:0] r,
    output logic       neg
);

    logic [6:0] base_r_s;
    logic       base_neg_s;

    // cosine quadrant fold
    always_comb begin
        base_r_s   = 7'd0;
        base_neg_s = 1'b0;
        if (d < 9'd90) begin
            base_r_s   = 7'(d);
            base_neg_s = 1'b0;
        end else if (d < 9'd180) begin
            base_r_s   = 7'(9'd180 - d);
            base_neg_s = 1'b1;
        end else if (d < 9'd270) begin
            base_r_s   = 7'(d - 9'd180);
            base_neg_s = 1'b1;
        end else begin
            base_r_s   = 7'(9'(DEG_FULL) - d);
            base_neg_s = 1'b0;
        end
    end

`ifdef COS_SIN_SEL_EN
    // sine is evaluated as cos(90-r) with its own half-plane sign
    always_comb begin
        r   = base_r_s;
        neg = base_neg_s;
        if (sin_sel) begin
            r   = 7'(DEG_QUARTER) - base_r_s;
            neg = (d >= 9'd180);
        end else begin
            r   = base_r_s;
            neg = base_neg_s;
        end
    end
`else
    assign r   = base_r_s;
    assign neg = base_neg_s;
`endif

endmodule

// File: rtl/cos_series_ctrl.sv
// Multicycle Taylor-series cosine sequencer with a valid/ready front and back.
// Optional macro COS_SIN_SEL_EN adds req_sin to evaluate sine instead.
module cos_series_ctrl
    import calc_pkg::*;
#(
    parameter int N_TERMS = 5,
    parameter int SCALE   = SCALE_FP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_deg,
`ifdef COS_SIN_SEL_EN
    input  logic        req_sin,
`endif
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_cos,
    output logic        busy
);

    localparam logic signed [17:0] SCALE_S = 18'(SCALE);
    localparam logic [2:0]         K_LAST  = 3'(N_TERMS - 1);

    cos_state_t         state_r, next_s;
    logic [15:0]        d_r;
    logic               sin_r;
    logic [15:0]        x2_r, term_r;
    logic signed [17:0] acc_r;
    logic [2:0]         k_r;
    logic [31:0]        prod_r;
    logic               neg_r;
    logic               req_ready_r, res_valid_r, busy_r;
    logic [15:0]        res_cos_r;

    logic [6:0]         r_s;
    logic               neg_s;
    logic [15:0]        x_s, x2_s, term_next_s, clamp_s;
    logic signed [17:0] acc_next_s;

`ifdef COS_SIN_SEL_EN
    cos_quadrant_map u_map (.d(d_r[8:0]), .sin_sel(sin_r), .r(r_s), .neg(neg_s));
`else
    cos_quadrant_map u_map (.d(d_r[8:0]), .r(r_s), .neg(neg_s));
    assign sin_r = 1'b0;
`endif

    // angle scaling, one series step on the shared datapath, and result clamp
    always_comb begin
        x_s         = 16'((32'(r_s) * 32'(SCALE) * RAD_NUM) / RAD_DEN);
        x2_s        = 16'((32'(x_s) * 32'(x_s)) / 32'(SCALE));
        term_next_s = 16'(prod_r / (32'(SCALE) * FACT_PAIR[k_r]));
        acc_next_s  = acc_r;
        if (k_r[0]) begin
            acc_next_s = acc_r - $signed({2'b00, term_next_s});
        end else begin
            acc_next_s = acc_r + $signed({2'b00, term_next_s});
        end
        clamp_s = 16'd0;
        if (acc_next_s < 18'sd0) begin
            clamp_s = 16'd0;
        end else if (acc_next_s > SCALE_S) begin
            clamp_s = 16'(SCALE);
        end else begin
            clamp_s = acc_next_s[15:0];
        end
    end

    // next-state logic
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid && req_ready_r) next_s = ST_REDUCE;
                else                          next_s = ST_IDLE;
            end
            ST_REDUCE: begin
                if (d_r >= 16'(DEG_FULL)) next_s = ST_REDUCE;
                else                      next_s = ST_SCALE;
            end
            ST_SCALE:    next_s = ST_TERM_MUL;
            ST_TERM_MUL: next_s = ST_TERM_DIV;
            ST_TERM_DIV: begin
                if (k_r == K_LAST) next_s = ST_DONE;
                else               next_s = ST_TERM_MUL;
            end
            ST_DONE: begin
                if (res_ready) next_s = ST_IDLE;
                else           next_s = ST_DONE;
            end
            default: next_s = ST_IDLE;
        endcase
    end

    // state register, datapath registers and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            d_r         <= 16'd0;
            x2_r        <= 16'd0;
            term_r      <= 16'd0;
            acc_r       <= 18'sd0;
            k_r         <= 3'd0;
            prod_r      <= 32'd0;
            neg_r       <= 1'b0;
            req_ready_r <= 1'b1;
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            res_cos_r   <= 16'd0;
        end else begin
            state_r     <= next_s;
            req_ready_r <= (next_s == ST_IDLE);
            busy_r      <= (next_s != ST_IDLE);
            res_valid_r <= (next_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && req_ready_r) d_r <= req_deg;
                    else                          d_r <= d_r;
                end
                ST_REDUCE: begin
                    if (d_r >= 16'(DEG_FULL)) d_r <= d_r - 16'(DEG_FULL);
                    else                      d_r <= d_r;
                end
                ST_SCALE: begin
                    x2_r   <= x2_s;
                    term_r <= 16'(SCALE);
                    acc_r  <= SCALE_S;
                    k_r    <= 3'd1;
                    neg_r  <= neg_s;
                end
                ST_TERM_MUL: prod_r <= 32'(term_r) * 32'(x2_r);
                ST_TERM_DIV: begin
                    term_r <= term_next_s;
                    acc_r  <= acc_next_s;
                    if (k_r == K_LAST) begin
                        res_cos_r <= neg_r ? (16'd0 - clamp_s) : clamp_s;
                    end else begin
                        k_r <= k_r + 3'd1;
                    end
                end
                ST_DONE: res_cos_r <= res_cos_r;
                default: d_r <= d_r;
            endcase
        end
    end

`ifdef COS_SIN_SEL_EN
    // capture the function select alongside the angle
    always_ff @(posedge clk) begin
        if (rst)                                  sin_r <= 1'b0;
        else if (state_r == ST_IDLE && req_valid) sin_r <= req_sin;
        else                                      sin_r <= sin_r;
    end
`endif

    assign req_ready = req_ready_r;
    assign res_valid = res_valid_r;
    assign res_cos   = res_cos_r;
    assign busy      = busy_r;

endmodule
